// File: rtl/multi_scaler.sv
// Multiplicity trigger scaler: per-channel threshold discriminators, a channel
// popcount, a paralysable holdoff and a gated interval counter with latch.
module multi_scaler #(
  parameter int NCH        = 3,
  parameter int ADC_WIDTH  = 12,
  parameter int CNT_WIDTH  = 32,
  parameter int HOLD_WIDTH = 8,
  parameter int MULT_WIDTH = 4
) (
  input  logic                      CLK120,
  input  logic                      RESET,
  input  logic [NCH*ADC_WIDTH-1:0]  ADC,
  input  logic [NCH*ADC_WIDTH-1:0]  THRES,
  input  logic [NCH-1:0]            TRIG_ENABLE,
  input  logic [MULT_WIDTH-1:0]     MULTIPLICITY,
  input  logic [HOLD_WIDTH-1:0]     HOLDOFF,
  input  logic                      LATCH,
  output logic [CNT_WIDTH-1:0]      COUNT,
  output logic [CNT_WIDTH-1:0]      COUNT_LATCHED,
  output logic                      OVF_LATCHED,
  output logic                      COUNT_VALID,
  output logic [2:0]                DEBUG
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  logic [NCH*ADC_WIDTH-1:0] adc_p0_q, adc_p0_d;
  logic [NCH*ADC_WIDTH-1:0] thres_p0_q, thres_p0_d;
  logic [NCH-1:0]           pmt_trig_p1_q, pmt_trig_p1_d;
  logic [MULT_WIDTH-1:0]    sum_p2_q, sum_p2_d;
  logic                     itrig_p3_q, itrig_p3_d;
  logic [HOLD_WIDTH-1:0]    hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]     count_latched_q, count_latched_d;
  logic                     ovf_latched_q, ovf_latched_d;
  logic                     count_valid_q, count_valid_d;
  logic [2:0]               debug_q, debug_d;
  logic                     hold_active, strobe, overflow;

  always_comb begin
    // p0: raw samples and thresholds
    adc_p0_d   = ADC;
    thres_p0_d = THRES;

    // p1: per-channel discriminators (strictly above threshold)
    pmt_trig_p1_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pmt_trig_p1_d[i] = (adc_p0_q[i*ADC_WIDTH +: ADC_WIDTH] >
                          thres_p0_q[i*ADC_WIDTH +: ADC_WIDTH]) && TRIG_ENABLE[i];
    end

    // p2: number of firing channels
    sum_p2_d = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_p2_d = sum_p2_d + MULT_WIDTH'(pmt_trig_p1_q[i]);
    end

    // p3: multiplicity trigger; zero multiplicity disables
    itrig_p3_d = (sum_p2_q >= MULTIPLICITY) && (MULTIPLICITY != '0);

    // count decision: holdoff reloads on every trigger cycle (paralysable)
    hold_active = (hcnt_q != '0);
    strobe      = itrig_p3_q && !hold_active;
    overflow    = strobe && (count_q == CNT_MAX);

    if (itrig_p3_q)       hcnt_d = HOLDOFF;
    else if (hold_active) hcnt_d = hcnt_q - HOLD_WIDTH'(1);
    else                  hcnt_d = hcnt_q;

    count_d         = sat_inc(count_q, strobe);
    ovf_d           = ovf_q | overflow;
    count_latched_d = count_latched_q;
    ovf_latched_d   = ovf_latched_q;
    if (LATCH) begin
      count_latched_d = count_d;
      ovf_latched_d   = ovf_d;
      count_d         = '0;
      ovf_d           = 1'b0;
    end
    count_valid_d = LATCH;
    debug_d       = {hold_active, itrig_p3_q, strobe};
  end

  always_ff @(posedge CLK120 or posedge RESET) begin
    if (RESET) begin
      adc_p0_q        <= '0;
      thres_p0_q      <= '0;
      pmt_trig_p1_q   <= '0;
      sum_p2_q        <= '0;
      itrig_p3_q      <= 1'b0;
      hcnt_q          <= '0;
      count_q         <= '0;
      ovf_q           <= 1'b0;
      count_latched_q <= '0;
      ovf_latched_q   <= 1'b0;
      count_valid_q   <= 1'b0;
      debug_q         <= '0;
    end else begin
      adc_p0_q        <= adc_p0_d;
      thres_p0_q      <= thres_p0_d;
      pmt_trig_p1_q   <= pmt_trig_p1_d;
      sum_p2_q        <= sum_p2_d;
      itrig_p3_q      <= itrig_p3_d;
      hcnt_q          <= hcnt_d;
      count_q         <= count_d;
      ovf_q           <= ovf_d;
      count_latched_q <= count_latched_d;
      ovf_latched_q   <= ovf_latched_d;
      count_valid_q   <= count_valid_d;
      debug_q         <= debug_d;
    end
  end

  assign COUNT         = count_q;
  assign COUNT_LATCHED = count_latched_q;
  assign OVF_LATCHED   = ovf_latched_q;
  assign COUNT_VALID   = count_valid_q;
  assign DEBUG         = debug_q;

endmodule
